// File: rtl/gpr_pkg.sv
// Shared types and constants for the general-purpose register file and its scoreboard.
package gpr_pkg;

    localparam int GPR_DATA_W = 16;
    localparam int GPR_NREGS  = 8;
    localparam int GPR_ADDR_W = $clog2(GPR_NREGS);

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

    localparam int                    ZERO_IDX      = 0;
    localparam logic [GPR_DATA_W-1:0] GPR_RESET_VAL = '0;

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue, cleared on writeback.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic              rd_use_1,
    input  logic              rd_use_2,
    input  logic              clr_1,
    input  logic              clr_2,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic              busy_any
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             iss_ok;
    logic             hit_1;
    logic             hit_2;

    assign iss_ok = iss_en && !(ZERO_REG && (iss_addr == ADDR_W'(ZERO_IDX)));

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hit_1    = busy[rd_addr_1] & ~clr_1;
    assign hit_2    = busy[rd_addr_2] & ~clr_2;
    assign stall    = (rd_use_1 & hit_1) | (rd_use_2 & hit_2);
    assign busy_vec = busy;
    assign busy_any = |busy;

endmodule

// File: rtl/gpr_file_sb.sv
// Register file with two async read ports, one sync write port, optional bypass and scoreboard.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic              rd_use_1,
    input  logic              rd_use_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic              busy_any
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok;
    logic              fwd_1;
    logic              fwd_2;
    logic              zero_1;
    logic              zero_2;
    logic              clr_1;
    logic              clr_2;

    assign wr_ok  = wr_en && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_IDX)));
    assign zero_1 = ZERO_REG && (rd_addr_1 == ADDR_W'(ZERO_IDX));
    assign zero_2 = ZERO_REG && (rd_addr_2 == ADDR_W'(ZERO_IDX));
    assign fwd_1  = BYPASS && wr_ok && (wr_addr == rd_addr_1);
    assign fwd_2  = BYPASS && wr_ok && (wr_addr == rd_addr_2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(GPR_RESET_VAL);
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads are forced to zero during reset so the ports never expose stale data.
    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        rd_data_2 = regs[rd_addr_2];
        if (fwd_1) begin
            rd_data_1 = wr_data;
        end
        if (fwd_2) begin
            rd_data_2 = wr_data;
        end
        if (rst || zero_1) begin
            rd_data_1 = '0;
        end
        if (rst || zero_2) begin
            rd_data_2 = '0;
        end
    end

    assign clr_1 = BYPASS && wr_en && (wr_addr == rd_addr_1);
    assign clr_2 = BYPASS && wr_en && (wr_addr == rd_addr_2);

    gpr_scoreboard #(
        .NREGS   (NREGS),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr_1(rd_addr_1),
        .rd_addr_2(rd_addr_2),
        .rd_use_1 (rd_use_1),
        .rd_use_2 (rd_use_2),
        .clr_1    (clr_1),
        .clr_2    (clr_2),
        .stall    (stall),
        .busy_vec (busy_vec),
        .busy_any (busy_any)
    );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench: dut_a has ZERO_REG=1/BYPASS=1, dut_b has ZERO_REG=0/BYPASS=0; both share stimulus.
module tb_gpr_file_sb;

    logic        clk;
    logic        rst;
    logic [2:0]  rd_addr_1;
    logic [2:0]  rd_addr_2;
    logic        rd_use_1;
    logic        rd_use_2;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_en;
    logic [2:0]  iss_addr;

    logic [15:0] a_rd_data_1, a_rd_data_2, b_rd_data_1, b_rd_data_2;
    logic        a_stall, b_stall, a_busy_any, b_busy_any;
    logic [7:0]  a_busy_vec, b_busy_vec;

    int checks;
    int failures;

    gpr_file_sb #(
        .DATA_W  (16),
        .NREGS   (8),
        .ZERO_REG(1'b1),
        .BYPASS  (1'b1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_1(rd_addr_1),
        .rd_addr_2(rd_addr_2),
        .rd_use_1 (rd_use_1),
        .rd_use_2 (rd_use_2),
        .rd_data_1(a_rd_data_1),
        .rd_data_2(a_rd_data_2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .stall    (a_stall),
        .busy_vec (a_busy_vec),
        .busy_any (a_busy_any)
    );

    gpr_file_sb #(
        .DATA_W  (16),
        .NREGS   (8),
        .ZERO_REG(1'b0),
        .BYPASS  (1'b0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_1(rd_addr_1),
        .rd_addr_2(rd_addr_2),
        .rd_use_1 (rd_use_1),
        .rd_use_2 (rd_use_2),
        .rd_data_1(b_rd_data_1),
        .rd_data_2(b_rd_data_2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .stall    (b_stall),
        .busy_vec (b_busy_vec),
        .busy_any (b_busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        rd_addr_1 = 3'd0;
        rd_addr_2 = 3'd0;
        rd_use_1  = 1'b0;
        rd_use_2  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 3'd0;
        wr_data   = 16'h0;
        iss_en    = 1'b0;
        iss_addr  = 3'd0;

        // Reset
        #1;
        check("rst_rd1_during", a_rd_data_1, 32'h0);
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_1 = 3'(i);
            rd_addr_2 = 3'(i);
            #1;
            check("rst_a_rd1", a_rd_data_1, 32'h0);
            check("rst_a_rd2", a_rd_data_2, 32'h0);
            check("rst_b_rd1", b_rd_data_1, 32'h0);
        end
        check("rst_a_busy", a_busy_vec, 32'h0);
        check("rst_b_busy", b_busy_vec, 32'h0);
        check("rst_a_stall", a_stall, 32'h0);
        check("rst_a_busy_any", a_busy_any, 32'h0);

        // Write then read
        tick;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        tick;
        idle;
        rd_addr_1 = 3'd3;
        #1;
        check("wr_a_r3", a_rd_data_1, 32'hBEEF);
        check("wr_b_r3", b_rd_data_1, 32'hBEEF);

        // Same-cycle bypass vs. stored value
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        #1;
        check("byp_a_r3", a_rd_data_1, 32'h1234);
        check("nobyp_b_r3_old", b_rd_data_1, 32'hBEEF);
        tick;
        idle;
        #1;
        check("byp_a_r3_after", a_rd_data_1, 32'h1234);
        check("nobyp_b_r3_after", b_rd_data_1, 32'h1234);

        // Zero register: write and issue to r0 together
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        iss_en = 1'b1; iss_addr = 3'd0;
        rd_addr_1 = 3'd0;
        #1;
        check("zero_a_byp_r0", a_rd_data_1, 32'h0);
        tick;
        idle;
        #1;
        check("zero_a_r0", a_rd_data_1, 32'h0);
        check("zero_a_busy", a_busy_vec, 32'h0);
        check("zero_b_r0", b_rd_data_1, 32'hFFFF);
        check("zero_b_busy", b_busy_vec, 32'h01);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0;
        tick;
        idle;
        #1;
        check("zero_b_busy_clr", b_busy_vec, 32'h0);

        // Load hazard on r5
        iss_en = 1'b1; iss_addr = 3'd5;
        rd_addr_2 = 3'd5; rd_use_2 = 1'b1;
        #1;
        check("ld_a_stall_issue_cycle", a_stall, 32'h0);
        tick;
        idle;
        #1;
        check("ld_a_busy", a_busy_vec, 32'h20);
        check("ld_a_busy_any", a_busy_any, 32'h1);
        check("ld_a_stall", a_stall, 32'h1);
        check("ld_b_stall", b_stall, 32'h1);
        rd_use_2 = 1'b0;
        #1;
        check("ld_a_nouse", a_stall, 32'h0);
        rd_use_2 = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00A5;
        #1;
        check("wb_a_stall", a_stall, 32'h0);
        check("wb_a_rd2", a_rd_data_2, 32'h00A5);
        check("wb_b_stall", b_stall, 32'h1);
        tick;
        idle;
        #1;
        check("wb_b_stall_next", b_stall, 32'h0);
        check("wb_b_rd2", b_rd_data_2, 32'h00A5);
        check("wb_a_busy", a_busy_vec, 32'h0);
        rd_use_2 = 1'b0;

        // Issue and writeback to r2 in the same cycle
        iss_en = 1'b1; iss_addr = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        tick;
        idle;
        rd_addr_1 = 3'd2;
        #1;
        check("sim_a_busy", a_busy_vec, 32'h04);
        check("sim_a_r2", a_rd_data_1, 32'h2222);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        tick;
        idle;
        // Issue r1 with writeback r4
        iss_en = 1'b1; iss_addr = 3'd1;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        tick;
        idle;
        #1;
        check("sim2_a_busy", a_busy_vec, 32'h02);
        check("sim2_b_busy", b_busy_vec, 32'h02);

        // Build busy = 0x2C, r6 = 0x5555, then async reset between edges
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
        iss_en = 1'b1; iss_addr = 3'd2;
        tick;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5555;
        iss_en = 1'b1; iss_addr = 3'd3;
        tick;
        wr_en = 1'b0;
        iss_en = 1'b1; iss_addr = 3'd5;
        tick;
        idle;
        rd_addr_1 = 3'd6;
        rd_addr_2 = 3'd3; rd_use_2 = 1'b1;
        #1;
        check("pre_a_busy", a_busy_vec, 32'h2C);
        check("pre_a_r6", a_rd_data_1, 32'h5555);
        check("pre_a_r3", a_rd_data_2, 32'h1234);
        check("pre_a_stall", a_stall, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_a_busy", a_busy_vec, 32'h0);
        check("arst_b_busy", b_busy_vec, 32'h0);
        check("arst_a_rd1", a_rd_data_1, 32'h0);
        check("arst_a_rd2", a_rd_data_2, 32'h0);
        check("arst_a_stall", a_stall, 32'h0);
        check("arst_a_busy_any", a_busy_any, 32'h0);
        tick;
        rst = 1'b0;
        #1;
        check("post_a_r6", a_rd_data_1, 32'h0);
        check("post_b_r6", b_rd_data_1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard for the 16-bit RISC core. It provides two asynchronous read ports, one synchronous write port and optional write-to-read bypass. A per-register busy bit is set when a multi-cycle producer (load or multiply) issues and cleared at writeback. The decode stage uses the resulting stall flag, so the core needs no separate hazard unit.

## Interface
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers; power of two, minimum 2
- ADDR_W, $clog2(NREGS), register address width (derived; never overridden)
- ZERO_REG, 0, 1 = register 0 reads as zero; writes and issues to it are ignored
- BYPASS, 1, 1 = same-cycle write data forwarded to the read ports
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_addr_2  in  ADDR_W  read port 2 address
- rd_use_1  in  1  read port 1 operand is consumed this cycle (gates stall)
- rd_use_2  in  1  read port 2 operand is consumed this cycle
- rd_data_1  out  DATA_W  read port 1 data
- rd_data_2  out  DATA_W  read port 2 data
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write data
- iss_en  in  1  multi-cycle producer issued; marks iss_addr busy
- iss_addr  in  ADDR_W  destination of the issued producer
- stall  out  1  a used source register is busy
- busy_vec  out  NREGS  per-register pending-write bits
- busy_any  out  1  OR of busy_vec

## Operation
- Reset (async assert, sync-safe release): all registers are 0, busy_vec = 0, and therefore stall = 0 and busy_any = 0. rd_data_* = 0 while rst is high.
- Write: on a rising edge with wr_en = 1, reg[wr_addr] <= wr_data. With ZERO_REG = 1 and wr_addr = 0, nothing happens.
- Read: combinational.
  - BYPASS = 1, wr_en = 1 and rd_addr_n == wr_addr (and not the zero register): rd_data_n = wr_data.
  - Otherwise rd_data_n = reg[rd_addr_n].
  - With ZERO_REG = 1, address 0 always reads 0.
- Scoreboard update on each rising edge:
  - wr_en clears busy[wr_addr].
  - iss_en sets busy[iss_addr].
  - iss_en and wr_en to the same address in the same cycle: set wins, so the register stays busy for the new producer.
  - Issue to the zero register (ZERO_REG = 1) is ignored.
  - Issue to an already-busy register keeps it busy; the scoreboard tracks one producer per register and does not count.
- stall = (rd_use_1 & hit_1) | (rd_use_2 & hit_2), where hit_n = busy[rd_addr_n] & ~clr_n.
  - clr_n = BYPASS & wr_en & (wr_addr == rd_addr_n), so a writeback in the current cycle resolves the hazard with no extra stall.
  - When BYPASS = 0, clr_n = 0 and the stall holds until the cycle after writeback.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Write-to-read latency: 0 cycles with BYPASS = 1; 1 cycle with BYPASS = 0, i.e. new data is visible after the edge.
- Issue-to-busy latency: 1 cycle. busy_vec and stall reflect an issue from the edge after iss_en, so the instruction immediately after a load sees the stall.
- stall, rd_data_* and busy_any are combinational from inputs and state. No registered outputs.
- Reset asserted mid-operation clears state immediately and asynchronously. An in-flight writeback or issue on the same edge is discarded.

## Structure
- Shared package gpr_pkg holds:
  - the gpr_addr_t typedef, parametrised through localparam defaults of DATA_W = 16 and NREGS = 8;
  - constants ZERO_IDX = 0 and GPR_RESET_VAL = '0.
- Sub-module gpr_scoreboard holds busy_vec, the set/clear logic and the stall computation, including the clr_n inputs. It is instantiated once.
- The data array and bypass muxes stay in the top level.

## Test plan
- Reset: assert rst, release, then read all 8 registers on both ports -> all read 0x0000; busy_vec = 0x00; stall = 0.
- Write then read:
  - write r3 = 0xBEEF; next cycle read rd_addr_1 = 3 -> 0xBEEF;
  - BYPASS = 1: same-cycle read of r3 during a write of 0x1234 -> 0x1234, while the stored value changes only after the edge.
- ZERO_REG = 1: write r0 = 0xFFFF and issue to r0 -> r0 reads 0x0000 and busy_vec[0] stays 0.
- Load hazard:
  - issue r5; next cycle rd_addr_2 = 5 with rd_use_2 = 1 -> stall = 1;
  - rd_use_2 = 0 -> stall = 0;
  - writeback r5 = 0x00A5 with BYPASS = 1 -> stall = 0 in that same cycle and rd_data_2 = 0x00A5;
  - with BYPASS = 0 -> stall = 1 in that cycle and 0 the next.
- Simultaneous events:
  - iss_en and wr_en to r2 in the same cycle -> busy[2] = 1 afterwards and r2 holds the written data;
  - issue r1 with writeback r4 in the same cycle -> busy = {r1} only.
- Async reset mid-operation: with busy_vec = 0x2C and r6 = 0x5555, assert rst between edges -> busy_vec = 0 and rd_data_* = 0 immediately, without waiting for a clock edge.
